// File: rtl/acc_sysreg_pkg.sv
// rtl/acc_sysreg_pkg.sv - opcodes, FSM states and condition-code bit positions
package acc_sysreg_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_SET   = 3'b010,
    OP_CMP   = 3'b011,
    OP_SYSRD = 3'b100,
    OP_SYSWR = 3'b101,
    OP_MAC   = 3'b110,
    OP_CLR   = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC1 = 1'b1
  } state_e;

  localparam int CC_ZERO = 0;
  localparam int CC_OVF  = 1;
  localparam int CC_NEG  = 2;

endpackage

// File: rtl/acc_sysreg_bank_if.sv
// rtl/acc_sysreg_bank_if.sv - request/result bus of the accumulator/sysreg bank
interface acc_sysreg_bank_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NACC = 16
);
  localparam int AW = $clog2(NACC);

  logic          req_valid_i_asb;
  logic          req_ready_o_asb;
  logic [2:0]    op_i_asb;
  logic [AW-1:0] acc_sel_i_asb;
  logic [DW-1:0] opr0_i_asb;
  logic [4:0]    imm5_i_asb;
  logic          src_sel_i_asb;
  logic          rslt_valid_o_asb;
  logic [DW-1:0] rslt_o_asb;
  logic [2:0]    rslt_cc_o_asb;

  modport master (
    output req_valid_i_asb, op_i_asb, acc_sel_i_asb, opr0_i_asb, imm5_i_asb, src_sel_i_asb,
    input  req_ready_o_asb, rslt_valid_o_asb, rslt_o_asb, rslt_cc_o_asb
  );

  modport slave (
    input  req_valid_i_asb, op_i_asb, acc_sel_i_asb, opr0_i_asb, imm5_i_asb, src_sel_i_asb,
    output req_ready_o_asb, rslt_valid_o_asb, rslt_o_asb, rslt_cc_o_asb
  );
endinterface

// File: rtl/acc_sysreg_alu.sv
// rtl/acc_sysreg_alu.sv - combinational add/sub with signed overflow flags and optional saturation
module acc_sysreg_alu
  import acc_sysreg_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          sub_i,
  input  logic          sat_ok_i,
  output logic [DW-1:0] res_o,
  output logic [2:0]    cc_o
);
  logic [DW-1:0] raw;
  logic          a_s;
  logic          b_s;
  logic          ovf;

  always_comb begin
    raw = sub_i ? (a_i - b_i) : (a_i + b_i);
    // Subtraction flips the effective sign of b, so one rule covers both directions.
    a_s = a_i[DW-1];
    b_s = b_i[DW-1] ^ sub_i;
    ovf = (a_s == b_s) && (raw[DW-1] != a_s);
    res_o = raw;
    if (SAT_EN && sat_ok_i && ovf) begin
      res_o = a_s ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    cc_o          = '0;
    cc_o[CC_NEG]  = res_o[DW-1];
    cc_o[CC_OVF]  = ovf;
    cc_o[CC_ZERO] = (res_o == '0);
  end
endmodule

// File: rtl/acc_sysreg_bank.sv
// rtl/acc_sysreg_bank.sv - accumulator bank with system registers and a two-cycle MAC
module acc_sysreg_bank
  import acc_sysreg_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned NACC    = 16,
  parameter int unsigned NSYS    = 8,
  parameter bit          SAT_EN  = 1'b0,
  parameter logic [31:0] VERSION = 32'h0000_0002
) (
  input logic              clk_i_asb,
  input logic              rst_i_asb,
  acc_sysreg_bank_if.slave bus
);
  localparam int AW = $clog2(NACC);
  localparam int SW = $clog2(NSYS);
  localparam logic [DW-1:0] VERSION_W = DW'(VERSION);

  state_e        state_q, state_d;
  logic [DW-1:0] acc_q [NACC];
  logic [DW-1:0] acc_d [NACC];
  logic [DW-1:0] sys_q [NSYS];
  logic [DW-1:0] sys_d [NSYS];
  logic [DW-1:0] mac_p_q, mac_p_d;
  logic [AW-1:0] mac_idx_q, mac_idx_d;
  logic [DW-1:0] rslt_q, rslt_d;
  logic [2:0]    cc_q, cc_d;
  logic          valid_q, valid_d;

  op_e           op;
  logic          accept;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] b_w;
  logic [DW-1:0] acc_rd;
  logic [SW-1:0] sys_idx;
  logic [DW-1:0] sys_rd;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic          alu_sub, alu_sat;
  logic [2:0]    alu_cc;

  function automatic logic [2:0] plain_cc(input logic [DW-1:0] v);
    plain_cc          = '0;
    plain_cc[CC_NEG]  = v[DW-1];
    plain_cc[CC_ZERO] = (v == '0);
  endfunction

  assign op      = op_e'(bus.op_i_asb);
  assign accept  = bus.req_valid_i_asb && (state_q == ST_IDLE);
  assign imm_ext = {{(DW-5){1'b0}}, bus.imm5_i_asb};
  assign b_w     = bus.src_sel_i_asb ? bus.opr0_i_asb : imm_ext;
  assign acc_rd  = acc_q[bus.acc_sel_i_asb];
  assign sys_idx = bus.imm5_i_asb[SW-1:0];
  assign sys_rd  = (sys_idx == '0) ? VERSION_W : sys_q[sys_idx];

  // The second MAC cycle borrows the adder for acc + product.
  always_comb begin
    alu_a   = acc_rd;
    alu_b   = b_w;
    alu_sub = (op == OP_SUB) || (op == OP_CMP);
    alu_sat = (op != OP_CMP);
    if (state_q == ST_MAC1) begin
      alu_a   = acc_q[mac_idx_q];
      alu_b   = mac_p_q;
      alu_sub = 1'b0;
      alu_sat = 1'b1;
    end
  end

  acc_sysreg_alu #(.DW(DW), .SAT_EN(SAT_EN)) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .sub_i    (alu_sub),
    .sat_ok_i (alu_sat),
    .res_o    (alu_res),
    .cc_o     (alu_cc)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sys_d     = sys_q;
    mac_p_d   = mac_p_q;
    mac_idx_d = mac_idx_q;
    rslt_d    = rslt_q;
    cc_d      = cc_q;
    valid_d   = 1'b0;
    if (state_q == ST_MAC1) begin
      acc_d[mac_idx_q] = alu_res;
      rslt_d  = alu_res;
      cc_d    = alu_cc;
      valid_d = 1'b1;
      state_d = ST_IDLE;
    end else if (accept) begin
      valid_d = 1'b1;
      case (op)
        OP_ADD, OP_SUB: begin
          acc_d[bus.acc_sel_i_asb] = alu_res;
          rslt_d = alu_res;
          cc_d   = alu_cc;
        end
        OP_SET: begin
          acc_d[bus.acc_sel_i_asb] = bus.opr0_i_asb;
          rslt_d = bus.opr0_i_asb;
          cc_d   = plain_cc(bus.opr0_i_asb);
        end
        OP_CMP: begin
          rslt_d = acc_rd;
          cc_d   = alu_cc;
        end
        OP_SYSRD: begin
          rslt_d = sys_rd;
          cc_d   = plain_cc(sys_rd);
        end
        OP_SYSWR: begin
          if (sys_idx != '0) sys_d[sys_idx] = bus.opr0_i_asb;
          rslt_d = bus.opr0_i_asb;
          cc_d   = plain_cc(bus.opr0_i_asb);
        end
        OP_MAC: begin
          valid_d   = 1'b0;
          mac_p_d   = bus.opr0_i_asb * imm_ext;
          mac_idx_d = bus.acc_sel_i_asb;
          state_d   = ST_MAC1;
        end
        OP_CLR: begin
          acc_d  = '{default: '0};
          rslt_d = '0;
          cc_d   = 3'b001;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i_asb or posedge rst_i_asb) begin
    if (rst_i_asb) begin
      state_q   <= ST_IDLE;
      acc_q     <= '{default: '0};
      sys_q     <= '{default: '0};
      mac_p_q   <= '0;
      mac_idx_q <= '0;
      rslt_q    <= '0;
      cc_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sys_q     <= sys_d;
      mac_p_q   <= mac_p_d;
      mac_idx_q <= mac_idx_d;
      rslt_q    <= rslt_d;
      cc_q      <= cc_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.req_ready_o_asb  = (state_q == ST_IDLE);
  assign bus.rslt_valid_o_asb = valid_q;
  assign bus.rslt_o_asb       = rslt_q;
  assign bus.rslt_cc_o_asb    = cc_q;
endmodule

// File: doc/acc_sysreg_bank.md
ACC_SYSREG_BANK -- requirements
Module: acc_sysreg_bank

Interface
REQ-001 SHALL have parameter DW, default 32, meaning accumulator/sysreg/operand width (>=8).
REQ-002 SHALL have parameter NACC, default 16, meaning accumulator count (power of two, 2..64).
REQ-003 SHALL have parameter NSYS, default 8, meaning sysreg count (power of two, 2..32).
REQ-004 SHALL have parameter SAT_EN, default 0, meaning 1 = saturate ADD/SUB/MAC writeback on signed overflow.
REQ-005 SHALL have parameter VERSION, default 32'h0000_0002, meaning read-only value of sysreg 0.
REQ-006 SHALL have ports: clk_i_asb in 1 clock; rst_i_asb in 1 reset, asynchronous, active-high.
REQ-007 SHALL have ports: req_valid_i_asb in 1 op request; req_ready_o_asb out 1 accept possible; op_i_asb in 3 opcode (000 ADD, 001 SUB, 010 SET, 011 CMP, 100 SYSRD, 101 SYSWR, 110 MAC, 111 CLR).
REQ-008 SHALL have ports: acc_sel_i_asb in log2(NACC) accumulator index; opr0_i_asb in DW operand; imm5_i_asb in 5 immediate / sysreg index; src_sel_i_asb in 1 (0 imm, 1 opr0).
REQ-009 SHALL have ports: rslt_valid_o_asb out 1 one-cycle result strobe; rslt_o_asb out DW result; rslt_cc_o_asb out 3 {negative, overflow, zero}.

Function
REQ-010 SHALL hold NACC accumulators and NSYS sysregs internally; sysreg index = imm5[log2(NSYS)-1:0]; B = src_sel ? opr0 : zero-extended imm5.
REQ-011 SHALL accept a request on a rising edge where req_valid & req_ready are both 1.
REQ-012 SHALL use FSM IDLE/MAC1: ready = 1 in IDLE, 0 in MAC1; any opcode except MAC stays in IDLE; MAC goes IDLE->MAC1->IDLE.
REQ-013 Non-MAC ops SHALL write back and register result/cc at the accept edge; rslt_valid high the following cycle (latency 1).
REQ-014 MAC SHALL register P = (opr0 * zero-extended imm5) truncated to DW at accept, and at the MAC1 edge write acc+P; rslt_valid high the cycle after (latency 2).
REQ-015 ADD: acc += B. SUB: acc -= B. Both write acc; result = written value.
REQ-016 SET SHALL write acc = opr0; result = opr0; overflow 0.
REQ-017 CMP SHALL compute acc-B, write nothing; result = acc unchanged; cc from the difference.
REQ-018 SYSRD SHALL return selected sysreg (sysreg 0 returns VERSION); overflow 0.
REQ-019 SYSWR SHALL write opr0 to selected sysreg and return opr0; write to index 0 ignored, result still opr0.
REQ-020 CLR SHALL zero all accumulators in one cycle; result 0, cc = 3'b001.
REQ-021 Overflow SHALL be true two's-complement signed overflow of the DW-bit ADD/SUB/MAC/CMP; zero = (result==0) or CMP difference==0; negative = MSB of same.
REQ-022 With SAT_EN=1 and overflow, ADD/SUB/MAC SHALL write and return {0,1...1} (positive) or {1,0...0} (negative); overflow flag still 1; CMP never saturates.
REQ-023 Back-to-back ops to the same accumulator SHALL see the previous write (no stale read).
REQ-024 rslt_o/rslt_cc_o SHALL hold last value between strobes.

Reset
REQ-025 Reset assertion SHALL immediately set state IDLE, all accumulators and sysregs 1..NSYS-1 to 0, rslt_o 0, rslt_cc_o 0, rslt_valid 0, req_ready 1 (after release).
REQ-026 Reset during MAC1 SHALL abort the MAC: no accumulator write, no rslt_valid.

Structure
REQ-027 Package acc_sysreg_pkg SHALL hold the opcode enum, FSM state enum and cc bit positions.
REQ-028 Sub-module acc_sysreg_alu SHALL be combinational: add/sub, overflow/zero/negative, saturation.

Verification
REQ-029 ADD acc3=0x7FFF_FFFF, imm 1, SAT_EN=0 -> acc3=0x8000_0000, cc=3'b110, rslt_valid 1 cycle later.
REQ-030 Same with SAT_EN=1 -> acc3=0x7FFF_FFFF, cc=3'b010.
REQ-031 MAC acc5=10, opr0=6, imm 7 -> ready 0 one cycle, acc5=52, strobe at cycle 2; request held valid during MAC1 is accepted only after.
REQ-032 SYSWR idx2=0xDEAD_BEEF then SYSRD idx2 -> 0xDEAD_BEEF; SYSWR idx0 then SYSRD idx0 -> VERSION.
REQ-033 CMP acc1=5, imm 5 -> cc=3'b001, acc1 still 5; CLR -> all accs 0.
REQ-034 Reset asserted in MAC1 -> acc unchanged (0), no strobe, ready 1 after release.
